// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU sequencer: ISA opcodes and state encodings.
package cpu_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_HLT  = 3'b000;
    localparam logic [OP_W-1:0] OP_SKZ  = 3'b001;
    localparam logic [OP_W-1:0] OP_ADD  = 3'b010;
    localparam logic [OP_W-1:0] OP_ANDD = 3'b011;
    localparam logic [OP_W-1:0] OP_XORR = 3'b100;
    localparam logic [OP_W-1:0] OP_LDA  = 3'b101;
    localparam logic [OP_W-1:0] OP_STO  = 3'b110;
    localparam logic [OP_W-1:0] OP_JMP  = 3'b111;

    localparam logic [3:0] ST_IDLE = 4'd0;
    localparam logic [3:0] ST_S0   = 4'd1;
    localparam logic [3:0] ST_S1   = 4'd2;
    localparam logic [3:0] ST_S2   = 4'd3;
    localparam logic [3:0] ST_S3   = 4'd4;
    localparam logic [3:0] ST_S4   = 4'd5;
    localparam logic [3:0] ST_S5   = 4'd6;
    localparam logic [3:0] ST_S6   = 4'd7;
    localparam logic [3:0] ST_S7   = 4'd8;
    localparam logic [3:0] ST_HALT = 4'd9;

    // Instructions that read an operand from memory and write the accumulator.
    function automatic logic is_alu_op(input logic [OP_W-1:0] op);
        return (op == OP_ADD) || (op == OP_ANDD) || (op == OP_XORR) || (op == OP_LDA);
    endfunction

endpackage

// File: rtl/cpu_seq_decode.sv
// Combinational strobe decode for the sequencer; op must already select the live
// opcode in S3 and the latched opcode afterwards.
module cpu_seq_decode
    import cpu_pkg::*;
(
    input  logic [3:0]      state,
    input  logic [OP_W-1:0] op,
    input  logic            zero,
    input  logic            skip_q,
    input  logic            mem_ready,
    output logic            rd,
    output logic            wr,
    output logic            load_ir,
    output logic            inc_pc,
    output logic            load_acc,
    output logic            load_pc,
    output logic            alu_ena,
    output logic            datactl_ena,
    output logic            halt
);

    always_comb begin
        rd          = 1'b0;
        wr          = 1'b0;
        load_ir     = 1'b0;
        inc_pc      = 1'b0;
        load_acc    = 1'b0;
        load_pc     = 1'b0;
        alu_ena     = 1'b0;
        datactl_ena = 1'b0;
        halt        = 1'b0;
        case (state)
            ST_S0: begin
                rd      = 1'b1;
                load_ir = mem_ready;
            end
            ST_S1: begin
                rd      = 1'b1;
                load_ir = mem_ready;
                inc_pc  = mem_ready;
            end
            ST_S3: inc_pc = (op != OP_HLT);
            ST_S4: begin
                if (is_alu_op(op)) begin
                    rd      = 1'b1;
                    alu_ena = mem_ready;
                end
                load_pc     = (op == OP_JMP);
                datactl_ena = (op == OP_STO);
            end
            ST_S5: begin
                load_acc    = is_alu_op(op);
                datactl_ena = (op == OP_STO);
                wr          = (op == OP_STO);
                // First half of the skip: the second increment in S6 clears the whole instruction.
                inc_pc      = (op == OP_SKZ) && zero;
            end
            ST_S6: begin
                datactl_ena = (op == OP_STO);
                inc_pc      = (op == OP_SKZ) && skip_q;
            end
            ST_HALT: halt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Instruction sequencer for the 8-bit accumulator CPU: fetch/decode/execute FSM,
// latched opcode, skip flag and retired-instruction counter.
//
// state | meaning
// IDLE  | waiting for ena
// S0    | fetch high instruction byte
// S1    | fetch low instruction byte, PC++
// S2    | bus turnaround
// S3    | decode, latch opcode, PC++ (or retire HLT)
// S4    | operand read / jump / store setup
// S5    | accumulator load / store write / zero test
// S6    | store hold / skip increment
// S7    | retire instruction
// HALT  | halted until reset
module cpu_seq_ctrl
    import cpu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             mem_ready,
    input  logic [OP_W-1:0]  opcode,
    input  logic             zero,
    output logic             rd,
    output logic             wr,
    output logic             load_ir,
    output logic             inc_pc,
    output logic             load_acc,
    output logic             load_pc,
    output logic             alu_ena,
    output logic             datactl_ena,
    output logic             halt,
    output logic [CNT_W-1:0] instr_cnt
);

    logic [3:0]       state_q, state_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic             skip_q, skip_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OP_W-1:0]  op_dec;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        skip_d  = skip_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: if (ena) state_d = ST_S0;
            ST_S0:   if (mem_ready) state_d = ST_S1;
            ST_S1:   if (mem_ready) state_d = ST_S2;
            ST_S2:   state_d = ST_S3;
            ST_S3: begin
                op_d = opcode;
                if (opcode == OP_HLT) begin
                    state_d = ST_HALT;
                    cnt_d   = cnt_q + 1'b1;
                end else begin
                    state_d = ST_S4;
                end
            end
            ST_S4:   if (!is_alu_op(op_q) || mem_ready) state_d = ST_S5;
            ST_S5: begin
                if (op_q == OP_SKZ) skip_d = zero;
                if (op_q != OP_STO || mem_ready) state_d = ST_S6;
            end
            ST_S6:   state_d = ST_S7;
            ST_S7: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = ena ? ST_S0 : ST_IDLE;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_HLT;
            skip_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            skip_q  <= skip_d;
            cnt_q   <= cnt_d;
        end
    end

    // op_q is only valid after S3, so the decode sees the live IR during S3 itself.
    assign op_dec    = (state_q == ST_S3) ? opcode : op_q;
    assign instr_cnt = cnt_q;

    cpu_seq_decode u_decode (
        .state       (state_q),
        .op          (op_dec),
        .zero        (zero),
        .skip_q      (skip_q),
        .mem_ready   (mem_ready),
        .rd          (rd),
        .wr          (wr),
        .load_ir     (load_ir),
        .inc_pc      (inc_pc),
        .load_acc    (load_acc),
        .load_pc     (load_pc),
        .alu_ena     (alu_ena),
        .datactl_ena (datactl_ena),
        .halt        (halt)
    );

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Directed bench for cpu_seq_ctrl: per-cycle strobe vectors and retire counts.
module tb_cpu_seq_ctrl;
    import cpu_pkg::*;

    localparam logic [8:0] NONE = 9'b0_0000_0000;
    localparam logic [8:0] RD   = 9'b1_0000_0000;
    localparam logic [8:0] WR   = 9'b0_1000_0000;
    localparam logic [8:0] LIR  = 9'b0_0100_0000;
    localparam logic [8:0] INC  = 9'b0_0010_0000;
    localparam logic [8:0] LACC = 9'b0_0001_0000;
    localparam logic [8:0] LPC  = 9'b0_0000_1000;
    localparam logic [8:0] ALU  = 9'b0_0000_0100;
    localparam logic [8:0] DCTL = 9'b0_0000_0010;
    localparam logic [8:0] HLTB = 9'b0_0000_0001;

    logic        clk = 1'b0;
    logic        rst_n, ena, mem_ready, zero;
    logic [2:0]  opcode;
    logic        rd, wr, load_ir, inc_pc, load_acc, load_pc, alu_ena, datactl_ena, halt;
    logic [15:0] instr_cnt;
    logic [8:0]  strobes;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign strobes = {rd, wr, load_ir, inc_pc, load_acc, load_pc, alu_ena, datactl_ena, halt};

    cpu_seq_ctrl #(.CNT_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .mem_ready   (mem_ready),
        .opcode      (opcode),
        .zero        (zero),
        .rd          (rd),
        .wr          (wr),
        .load_ir     (load_ir),
        .inc_pc      (inc_pc),
        .load_acc    (load_acc),
        .load_pc     (load_pc),
        .alu_ena     (alu_ena),
        .datactl_ena (datactl_ena),
        .halt        (halt),
        .instr_cnt   (instr_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, check strobes mid-cycle, then step past the rising edge.
    task automatic cyc(input string tag, input logic e, input logic mr,
                       input logic [2:0] op, input logic z, input logic [8:0] exp);
        ena       = e;
        mem_ready = mr;
        opcode    = op;
        zero      = z;
        @(negedge clk);
        chk(tag, {23'd0, strobes}, {23'd0, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input string tag, input logic [2:0] op, input logic z);
        cyc({tag, "_s0"}, 1'b1, 1'b1, op, z, RD | LIR);
        cyc({tag, "_s1"}, 1'b1, 1'b1, op, z, RD | LIR | INC);
        cyc({tag, "_s2"}, 1'b1, 1'b1, op, z, NONE);
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b1; mem_ready = 1'b1; opcode = OP_LDA; zero = 1'b0;
        @(posedge clk); #1;
        cyc("rst_cycle", 1'b1, 1'b1, OP_LDA, 1'b0, NONE);
        chk("rst_cnt", {16'd0, instr_cnt}, 32'd0);
        rst_n = 1'b1;
        cyc("idle", 1'b1, 1'b1, OP_LDA, 1'b0, NONE);

        fetch("lda", OP_LDA, 1'b0);
        cyc("lda_s3", 1'b1, 1'b1, OP_LDA, 1'b0, INC);
        cyc("lda_s4", 1'b1, 1'b1, OP_LDA, 1'b0, RD | ALU);
        cyc("lda_s5", 1'b1, 1'b1, OP_LDA, 1'b0, LACC);
        cyc("lda_s6", 1'b1, 1'b1, OP_LDA, 1'b0, NONE);
        cyc("lda_s7", 1'b1, 1'b1, OP_LDA, 1'b0, NONE);
        chk("lda_cnt", {16'd0, instr_cnt}, 32'd1);

        fetch("skz1", OP_SKZ, 1'b1);
        cyc("skz1_s3", 1'b1, 1'b1, OP_SKZ, 1'b1, INC);
        cyc("skz1_s4", 1'b1, 1'b1, OP_SKZ, 1'b1, NONE);
        cyc("skz1_s5", 1'b1, 1'b1, OP_SKZ, 1'b1, INC);
        cyc("skz1_s6", 1'b1, 1'b1, OP_SKZ, 1'b0, INC);
        cyc("skz1_s7", 1'b1, 1'b1, OP_SKZ, 1'b0, NONE);
        chk("skz1_cnt", {16'd0, instr_cnt}, 32'd2);

        fetch("skz0", OP_SKZ, 1'b0);
        cyc("skz0_s3", 1'b1, 1'b1, OP_SKZ, 1'b0, INC);
        cyc("skz0_s4", 1'b1, 1'b1, OP_SKZ, 1'b0, NONE);
        cyc("skz0_s5", 1'b1, 1'b1, OP_SKZ, 1'b0, NONE);
        cyc("skz0_s6", 1'b1, 1'b1, OP_SKZ, 1'b1, NONE);
        cyc("skz0_s7", 1'b1, 1'b1, OP_SKZ, 1'b0, NONE);
        chk("skz0_cnt", {16'd0, instr_cnt}, 32'd3);

        fetch("sto", OP_STO, 1'b0);
        cyc("sto_s3", 1'b1, 1'b1, OP_STO, 1'b0, INC);
        cyc("sto_s4", 1'b1, 1'b1, OP_STO, 1'b0, DCTL);
        for (int i = 0; i < 3; i++)
            cyc("sto_s5_stall", 1'b1, 1'b0, OP_STO, 1'b0, DCTL | WR);
        cyc("sto_s5", 1'b1, 1'b1, OP_STO, 1'b0, DCTL | WR);
        cyc("sto_s6", 1'b1, 1'b1, OP_STO, 1'b0, DCTL);
        cyc("sto_s7", 1'b1, 1'b1, OP_STO, 1'b0, NONE);
        chk("sto_cnt", {16'd0, instr_cnt}, 32'd4);

        // IR changes after S3 must not alter the latched JMP.
        fetch("jmp", OP_JMP, 1'b0);
        cyc("jmp_s3", 1'b1, 1'b1, OP_JMP, 1'b0, INC);
        cyc("jmp_s4", 1'b1, 1'b1, OP_LDA, 1'b1, LPC);
        cyc("jmp_s5", 1'b1, 1'b1, OP_SKZ, 1'b1, NONE);
        cyc("jmp_s6", 1'b1, 1'b1, OP_STO, 1'b1, NONE);
        cyc("jmp_s7", 1'b1, 1'b1, OP_SKZ, 1'b1, NONE);
        chk("jmp_cnt", {16'd0, instr_cnt}, 32'd5);

        cyc("add_s0_stall", 1'b1, 1'b0, OP_ADD, 1'b0, RD);
        cyc("add_s0_stall", 1'b1, 1'b0, OP_ADD, 1'b0, RD);
        fetch("add", OP_ADD, 1'b0);
        cyc("add_s3", 1'b1, 1'b1, OP_ADD, 1'b0, INC);
        cyc("add_s4_stall", 1'b1, 1'b0, OP_ADD, 1'b0, RD);
        cyc("add_s4", 1'b1, 1'b1, OP_ADD, 1'b0, RD | ALU);
        cyc("add_s5", 1'b1, 1'b1, OP_ADD, 1'b0, LACC);
        cyc("add_s6", 1'b1, 1'b1, OP_ADD, 1'b0, NONE);
        cyc("add_s7", 1'b1, 1'b1, OP_ADD, 1'b0, NONE);
        chk("add_cnt", {16'd0, instr_cnt}, 32'd6);

        fetch("hlt", OP_HLT, 1'b0);
        cyc("hlt_s3", 1'b1, 1'b1, OP_HLT, 1'b0, NONE);
        chk("hlt_cnt", {16'd0, instr_cnt}, 32'd7);
        for (int i = 0; i < 20; i++)
            cyc("halt_hold", i[0], 1'b1, OP_ADD, 1'b0, HLTB);
        rst_n = 1'b0;
        cyc("halt_rst", 1'b1, 1'b1, OP_ADD, 1'b0, HLTB);
        rst_n = 1'b1;
        chk("halt_rst_cnt", {16'd0, instr_cnt}, 32'd0);
        cyc("post_rst_idle", 1'b1, 1'b1, OP_ADD, 1'b0, NONE);

        cyc("add2_s0", 1'b1, 1'b1, OP_ADD, 1'b0, RD | LIR);
        cyc("add2_s1", 1'b1, 1'b1, OP_ADD, 1'b0, RD | LIR | INC);
        cyc("add2_s2", 1'b0, 1'b1, OP_ADD, 1'b0, NONE);
        cyc("add2_s3", 1'b0, 1'b1, OP_ADD, 1'b0, INC);
        cyc("add2_s4", 1'b0, 1'b1, OP_ADD, 1'b0, RD | ALU);
        cyc("add2_s5", 1'b0, 1'b1, OP_ADD, 1'b0, LACC);
        cyc("add2_s6", 1'b0, 1'b1, OP_ADD, 1'b0, NONE);
        cyc("add2_s7", 1'b0, 1'b1, OP_ADD, 1'b0, NONE);
        chk("add2_cnt", {16'd0, instr_cnt}, 32'd1);
        cyc("add2_idle", 1'b0, 1'b1, OP_ADD, 1'b0, NONE);
        cyc("add2_idle2", 1'b1, 1'b1, OP_ADD, 1'b0, NONE);

        fetch("lda2", OP_LDA, 1'b0);
        cyc("lda2_s3", 1'b1, 1'b1, OP_LDA, 1'b0, INC);
        cyc("lda2_s4", 1'b1, 1'b1, OP_LDA, 1'b0, RD | ALU);
        rst_n = 1'b0;
        cyc("lda2_s5_rst", 1'b1, 1'b1, OP_LDA, 1'b0, LACC);
        rst_n = 1'b1;
        chk("lda2_rst_cnt", {16'd0, instr_cnt}, 32'd1 - 32'd1);
        cyc("lda2_after_rst", 1'b0, 1'b1, OP_LDA, 1'b0, NONE);
        cyc("lda2_after_rst2", 1'b0, 1'b1, OP_LDA, 1'b0, NONE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
